regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-side front end of the 32×32 integer register file. Merges single-cycle ALU results and out-of-order load responses into the file's single write port, and keeps a 32-bit pending-load scoreboard that decode queries for RAW hazards. Accepted results reach the file as registered `we`/`waddr`/`wdata`, which the file samples on the following falling clock edge.

## Interface

Parameters:
- `XLEN`, 32, data width.
- `FIFO_DEPTH`, 2, load-response buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 4, consecutive cycles a buffered load may lose arbitration before it is forced through.

Ports:
- `clk`, in, 1, clock; all state updates on rising edge.
- `rst`, in, 1, reset; **asynchronous, active-high**.
- `alu_valid`, in, 1, ALU result present.
- `alu_ready`, out, 1, ALU result accepted this cycle when `alu_valid && alu_ready`.
- `alu_rd`, in, 5, ALU destination.
- `alu_data`, in, XLEN, ALU result.
- `ld_issue`, in, 1, decode issued a load this cycle.
- `ld_issue_rd`, in, 5, destination of that load.
- `ld_valid`, in, 1, load response present.
- `ld_ready`, out, 1, buffer not full.
- `ld_rd`, in, 5, load destination.
- `ld_data`, in, XLEN, load data.
- `we`, out, 1, register-file write enable.
- `waddr`, out, 5, register-file write address.
- `wdata`, out, XLEN, register-file write data.
- `q_addr1`, `q_addr2`, in, 5, scoreboard query addresses.
- `q_busy1`, `q_busy2`, out, 1, combinational pending bit for each query address.
- `err`, out, 1, sticky: load response arrived for a register that was not pending.

## Operation

- Load responses enter `wb_skid_fifo` on `ld_valid && ld_ready`. `ld_ready = !full`. The ALU never passes through the buffer.
- Arbitration each cycle, between the ALU and the FIFO head:
  - default: the ALU wins; `alu_ready=1`; the FIFO head commits only when `alu_valid=0`.
  - starve counter (width clog2(STARVE_LIMIT+1)) increments on each cycle the FIFO is non-empty and the head does not commit; it clears on every head commit.
  - when the counter equals `STARVE_LIMIT`: `alu_ready=0` for that cycle and the head commits.
- Commit: register `we=1`, `waddr=rd`, `wdata=data` for the next cycle. If `rd==0`, the item is still consumed but `we` stays 0.
- Scoreboard, `pending[31:0]`:
  - set bit `ld_issue_rd` on `ld_issue` (ignored for rd 0).
  - clear bit `rd` when the FIFO head commits.
  - same-cycle set and clear of the same bit: set wins.
  - `pending[0]` is constantly 0.
- `q_busyN = pending[q_addrN]`. No write forwarding; the register file provides its own.
- `err` sets when a response enters the FIFO with `pending[ld_rd]==0` and `ld_rd!=0`. Only reset clears it.

## Timing

- Reset values: `we=0`, `waddr=0`, `wdata=0`, `pending=0`, FIFO empty (`ld_ready=1`), starve counter 0, `err=0`. With the FIFO empty, `alu_ready=1`.
- Reset asserted mid-operation: all buffered loads are discarded and all pending bits cleared in the same instant. No write is emitted after `rst` rises.
- ALU latency: accepted at cycle N → `we` high during N+1 → register-file write at the falling edge inside N+1.
- Load latency: accepted at N → FIFO head at N+1 → earliest `we` in N+2. Each ALU win extends this by one cycle. Worst case is STARVE_LIMIT+2 cycles from acceptance to `we`.
- One write per cycle maximum. `we` is deasserted in any cycle after no commit.
- FIFO full with `ld_valid` high: response held, `ld_ready=0`. In the same cycle the head may commit, but `ld_ready` does not combinationally reflect the freed slot; it rises the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. A count of FIFO_DEPTH means full; a count of 0 means empty.

## Structure

- Shared package `rv_pkg`: `XLEN`, `REG_ADDR_W=5`, `NUM_REGS=32`, `REG_ZERO=5'd0`.
- Sub-module `wb_skid_fifo`: synchronous FIFO of {rd, data} with `push`/`pop`/`full`/`empty`/`head`, asynchronous active-high reset.
- The top level holds the arbiter, starve counter, scoreboard, output registers and `err`.

## Test plan

- Reset, then ALU rd=5, data=0x1234 at cycle 3 → `we=1`, `waddr=5`, `wdata=0x1234` in cycle 4 only.
- ALU write with rd=0 → consumed (`alu_ready=1`), `we` stays 0. `ld_issue` rd=0 → `q_busy1` for addr 0 stays 0.
- `ld_issue` rd=7, then response rd=7, data=0xDEAD with the ALU idle → `q_busy1` (q_addr1=7) high from the next cycle; `we`/`waddr=7` two cycles after acceptance; busy clears at the commit edge.
- ALU valid every cycle while one load is buffered, STARVE_LIMIT=4 → `alu_ready=0` on exactly one cycle after 4 losses; the load commits that cycle; the ALU item is held and written next.
- Three back-to-back load responses with the ALU busy → `ld_ready` drops after 2; the third enters after the first commit; all three are written in order.
- Response for rd=9 that was never issued → `err=1` and stays high. Assert `rst` mid-stream with the FIFO full → FIFO empty, `pending=0`, `we=0` immediately.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants for the integer register file and its write-side logic.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_skid_fifo.sv
// Small synchronous FIFO holding {rd, data} load responses until they win
// the register-file write port.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write din when push && !full
//   pop           drop the head when pop && !empty
//   head          current head entry (undefined while empty)
//   full, empty   occupancy flags
module wb_skid_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while the count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the 32x32 register file. Merges ALU results and
// buffered load responses onto one registered write port and tracks which
// registers still await a load (RAW scoreboard for decode).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result handshake
//   ld_issue, ld_issue_rd         decode issued a load to ld_issue_rd
//   ld_valid/ld_ready/ld_rd/ld_data      load response handshake
//   we, waddr, wdata              registered register-file write port
//   q_addr1/2, q_busy1/2          scoreboard queries (combinational)
//   err                           sticky: response for a non-pending register
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its payload stable until then, and ready
// never depends combinationally on the same cycle's valid.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  err
);
  localparam int EW = REG_ADDR_W + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [EW-1:0]         head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  force_head;
  logic                  head_commit;
  logic                  alu_commit;
  logic [SW-1:0]         starve;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;

  wb_skid_fifo #(
    .W    (EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  ({ld_rd, ld_data}),
    .pop  (head_commit),
    .head (head),
    .full (full),
    .empty(empty)
  );

  assign {head_rd, head_data} = head;

  // ld_ready reflects only the registered occupancy, so a slot freed by a
  // same-cycle commit becomes visible one cycle later.
  assign ld_ready = !full;
  assign push     = ld_valid && ld_ready;

  // The ALU wins by default; a head that has lost STARVE_LIMIT times in a
  // row takes the port and stalls the ALU for exactly that cycle.
  assign force_head  = !empty && (starve == STARVE_MAX);
  assign alu_ready   = !force_head;
  assign head_commit = !empty && (force_head || !alu_valid);
  assign alu_commit  = alu_valid && !force_head;

  assign q_busy1 = pending[q_addr1];
  assign q_busy2 = pending[q_addr2];

  // Clear on commit first, then set on issue, so a same-cycle set wins.
  always_comb begin
    pending_next = pending;
    if (head_commit) pending_next[head_rd] = 1'b0;
    if (ld_issue)    pending_next[ld_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      starve  <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pending_next;

      // Writes to x0 are consumed but never reach the file.
      we <= 1'b0;
      if (head_commit) begin
        we    <= (head_rd != REG_ZERO);
        waddr <= head_rd;
        wdata <= head_data;
      end else if (alu_commit) begin
        we    <= (alu_rd != REG_ZERO);
        waddr <= alu_rd;
        wdata <= alu_data;
      end

      if (head_commit)  starve <= '0;
      else if (!empty)  starve <= starve + 1'b1;

      if (push && (ld_rd != REG_ZERO) && !pending[ld_rd]) err <= 1'b1;
    end
  end
endmodule
